systolic_mm: RTL and testbench

Output-stationary SIZE x SIZE systolic matrix-multiply engine with built-in input skewing and a start/done and valid/ready handshake. It generalises the existing systolic array in four ways: inner dimension K is set per run, signed and unsigned modes are supported, input bubbles are tolerated, and overflow is flagged. The block sits between the operand-fetch logic, which streams one column of A and one row of B per beat, and the result collector, which reads all of out[][] when done pulses.

---
 rtl/systolic_mm.sv | 168 ++++++++++++++++
 tb/tb_systolic_mm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm.sv
// systolic_mm: output-stationary SIZE x SIZE systolic matrix multiply with input skew, start/done and valid/ready handshake
// Ports:
//   clk, reset (async, active-low)
//   start, k_len           : begin a run of k_len beats (sampled in IDLE)
//   busy, err              : run in progress / one-cycle pulse on a rejected start
//   in_valid, in_ready     : beat handshake; a_col[i] = A[i][k], b_row[j] = B[k][j]
//   done, ovf, out[i][j]   : completion pulse, sticky overflow, C[i][j] accumulators
module systolic_mm #(
  parameter int SIZE = 2,
  parameter int IN_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int K_MAX = 16,
  parameter int SIGNED = 0,
  localparam int KW = $clog2(K_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  a_col [SIZE],
  input  logic [IN_WIDTH-1:0]  b_row [SIZE],
  output logic                 done,
  output logic                 ovf,
  output logic [OUT_WIDTH-1:0] out [SIZE][SIZE]
);
  localparam int DW = $clog2(2 * SIZE);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [KW-1:0] cnt, klen;
  logic [DW-1:0] dcnt;
  logic go, reject, accept, last, drained, any_ovf;
  logic [IN_WIDTH-1:0] a_new [SIZE], b_new [SIZE], a_d [SIZE], b_d [SIZE];
  logic [IN_WIDTH-1:0] a_p [SIZE][SIZE], b_p [SIZE][SIZE];
  logic v_d [SIZE];
  logic v_p [SIZE][SIZE];
  logic [OUT_WIDTH-1:0] prod [SIZE][SIZE];
  logic [OUT_WIDTH:0] sum [SIZE][SIZE];

  function automatic logic [OUT_WIDTH-1:0] ext(input logic [IN_WIDTH-1:0] x);
    return {{(OUT_WIDTH - IN_WIDTH){SIGNED != 0 && x[IN_WIDTH-1]}}, x};
  endfunction

  assign go = state == IDLE && start && k_len <= KW'(K_MAX);
  assign reject = state == IDLE && start && k_len > KW'(K_MAX);
  assign accept = state == FEED && in_valid;
  assign last = accept && cnt == klen - KW'(1);
  assign drained = state == DRAIN && dcnt == DW'(2 * SIZE - 2);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? (k_len == '0 ? DONE : FEED) : IDLE;
      FEED:    nxt = last ? DRAIN : FEED;
      DRAIN:   nxt = drained ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
    busy = state != IDLE;
    in_ready = state == FEED;
    done = state == DONE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      klen <= '0;
      dcnt <= '0;
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      err <= reject;
      if (go) begin
        klen <= k_len;
        cnt <= '0;
      end else if (accept) cnt <= cnt + KW'(1);
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
      ovf <= go ? 1'b0 : ovf | any_ovf;
    end

  // Bubbles enter the array as zero data with a cleared tag so alignment survives stalls.
  always_comb begin
    a_new = '{default: '0};
    b_new = '{default: '0};
    for (int i = 0; i < SIZE; i++) begin
      a_new[i] = accept ? a_col[i] : '0;
      b_new[i] = accept ? b_row[i] : '0;
    end
  end

  // Row i of A and column i of B are delayed i cycles before entering the array edge.
  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_d[0] = a_new[0];
      assign b_d[0] = b_new[0];
      assign v_d[0] = accept;
    end else begin : g_delay
      logic [IN_WIDTH-1:0] a_sr [i], b_sr [i];
      logic v_sr [i];
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
            v_sr[d] <= 1'b0;
          end
        end else begin
          a_sr[0] <= a_new[i];
          b_sr[0] <= b_new[i];
          v_sr[0] <= accept;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
            v_sr[d] <= v_sr[d-1];
          end
        end
      assign a_d[i] = a_sr[i-1];
      assign b_d[i] = b_sr[i-1];
      assign v_d[i] = v_sr[i-1];
    end
  end

  // Operands are extended to OUT_WIDTH before multiplying; the low OUT_WIDTH bits equal the extended 2*IN_WIDTH product.
  always_comb begin
    prod = '{default: '0};
    sum = '{default: '0};
    any_ovf = 1'b0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        prod[i][j] = ext(a_p[i][j]) * ext(b_p[i][j]);
        sum[i][j] = {1'b0, out[i][j]} + {1'b0, prod[i][j]};
        any_ovf = any_ovf | (v_p[i][j] & (SIGNED != 0 ?
          (out[i][j][OUT_WIDTH-1] == prod[i][j][OUT_WIDTH-1] && sum[i][j][OUT_WIDTH-1] != out[i][j][OUT_WIDTH-1]) :
          sum[i][j][OUT_WIDTH]));
      end
  end

  // a_p/b_p/v_p hold the operands presented to PE(i,j) this cycle; a moves right, b moves down.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          a_p[i][j] <= '0;
          b_p[i][j] <= '0;
          v_p[i][j] <= 1'b0;
          out[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        a_p[i][0] <= a_d[i];
        v_p[i][0] <= v_d[i];
        b_p[0][i] <= b_d[i];
        for (int j = 1; j < SIZE; j++) begin
          a_p[i][j] <= a_p[i][j-1];
          v_p[i][j] <= v_p[i][j-1];
          b_p[j][i] <= b_p[j-1][i];
        end
        for (int j = 0; j < SIZE; j++)
          out[i][j] <= go ? '0 : v_p[i][j] ? sum[i][j][OUT_WIDTH-1:0] : out[i][j];
      end
    end
endmodule

// File: tb/tb_systolic_mm.sv
// tb_systolic_mm: directed and randomized checks of systolic_mm against an arithmetic matrix-product model
module tb_systolic_mm;
  localparam int S = 3, IW = 8, OW = 16, KM = 16, KW = 5;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic m_start, m_valid, m_busy, m_err, m_ready, m_done, m_ovf;
  logic [KW-1:0] m_k;
  logic [IW-1:0] m_a [S], m_b [S];
  logic [OW-1:0] m_out [S][S];
  logic s_start, s_valid, s_busy, s_err, s_ready, s_done, s_ovf;
  logic [KW-1:0] s_k;
  logic [7:0] s_a [2], s_b [2];
  logic [31:0] s_out [2][2];
  int total = 0, bad = 0;
  int A [3][16], B [16][3];
  longint exp_c [3][3];
  bit exp_ovf;

  systolic_mm #(.SIZE(S), .IN_WIDTH(IW), .OUT_WIDTH(OW), .K_MAX(KM), .SIGNED(0)) u_m (
    .clk(clk), .reset(reset), .start(m_start), .k_len(m_k), .busy(m_busy), .err(m_err),
    .in_valid(m_valid), .in_ready(m_ready), .a_col(m_a), .b_row(m_b), .done(m_done),
    .ovf(m_ovf), .out(m_out));

  systolic_mm #(.SIZE(2), .IN_WIDTH(8), .OUT_WIDTH(32), .K_MAX(KM), .SIGNED(1)) u_s (
    .clk(clk), .reset(reset), .start(s_start), .k_len(s_k), .busy(s_busy), .err(s_err),
    .in_valid(s_valid), .in_ready(s_ready), .a_col(s_a), .b_row(s_b), .done(s_done),
    .ovf(s_ovf), .out(s_out));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic f_done(input bit sd); return sd ? s_done : m_done; endfunction
  function automatic logic f_busy(input bit sd); return sd ? s_busy : m_busy; endfunction
  function automatic logic f_ready(input bit sd); return sd ? s_ready : m_ready; endfunction
  function automatic logic f_ovf(input bit sd); return sd ? s_ovf : m_ovf; endfunction

  // C = A x B over the first k terms, accumulated in beat order with wrap to the result width.
  function automatic void model(input bit sd, input int k);
    int n = sd ? 2 : 3;
    int ow = sd ? 32 : 16;
    longint mask = (longint'(1) << ow) - 1;
    longint acc, t, w;
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          t = acc + longint'(A[i][kk]) * longint'(B[kk][j]);
          w = t & mask;
          if (sd && w >= (longint'(1) << (ow - 1))) w -= (longint'(1) << ow);
          if (w != t) exp_ovf = 1'b1;
          acc = w;
        end
        exp_c[i][j] = acc;
      end
  endfunction

  task automatic check_result(input bit sd, input string tag);
    int n = sd ? 2 : 3;
    longint mask = (longint'(1) << (sd ? 32 : 16)) - 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        chk($sformatf("%s c%0d%0d", tag, i, j), sd ? 64'(s_out[i][j]) : 64'(m_out[i][j]), 64'(exp_c[i][j] & mask));
    chk({tag, " ovf"}, 64'(f_ovf(sd)), 64'(exp_ovf));
  endtask

  task automatic set_start(input bit sd, input bit st, input int k);
    if (sd) begin
      s_start = st;
      s_k = KW'(k);
    end else begin
      m_start = st;
      m_k = KW'(k);
    end
  endtask

  task automatic set_in(input bit sd, input bit v, input int beat);
    if (sd) begin
      s_valid = v;
      for (int i = 0; i < 2; i++) begin
        s_a[i] = v ? 8'(A[i][beat]) : 8'($urandom);
        s_b[i] = v ? 8'(B[beat][i]) : 8'($urandom);
      end
    end else begin
      m_valid = v;
      for (int i = 0; i < S; i++) begin
        m_a[i] = v ? IW'(A[i][beat]) : IW'($urandom);
        m_b[i] = v ? IW'(B[beat][i]) : IW'($urandom);
      end
    end
  endtask

  task automatic fill(input bit sd, input int hi);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = sd ? int'($urandom_range(255)) - 128 : int'($urandom_range(hi));
        B[k][i] = sd ? int'($urandom_range(255)) - 128 : int'($urandom_range(hi));
      end
  endtask

  // gap_pct < 0 inserts exactly two bubbles between beats 1 and 2; otherwise bubbles are random.
  task automatic run(input bit sd, input int k, input int gap_pct, input bit drain_start, input string tag);
    int n = sd ? 2 : 3;
    int g = 0, cyc = 0, beat = 0, w = 0;
    bit v;
    set_start(sd, 1'b1, k);
    @(posedge clk); #1;
    set_start(sd, 1'b0, 0);
    chk({tag, " busy"}, 64'(f_busy(sd)), 64'd1);
    while (beat < k && cyc < 400) begin
      v = gap_pct < 0 ? !(beat == 1 && g < 2) : $urandom_range(99) >= gap_pct;
      chk({tag, " ready"}, 64'(f_ready(sd)), 64'd1);
      set_in(sd, v, beat);
      @(posedge clk); #1;
      cyc++;
      if (v) beat++;
      else g++;
    end
    set_in(sd, 1'b0, 0);
    if (drain_start) set_start(sd, 1'b1, 1);
    while (!f_done(sd) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    set_start(sd, 1'b0, 0);
    chk({tag, " done latency"}, 64'(w), 64'(2 * n - 1));
    model(sd, k);
    check_result(sd, tag);
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 64'(f_done(sd)), 64'd0);
    chk({tag, " idle"}, 64'(f_busy(sd)), 64'd0);
  endtask

  task automatic load_s1();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = 0;
        B[k][i] = 0;
      end
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
  endtask

  initial begin
    int seen;
    m_start = 1'b0; m_valid = 1'b0; m_k = '0;
    s_start = 1'b0; s_valid = 1'b0; s_k = '0;
    for (int i = 0; i < S; i++) begin m_a[i] = '0; m_b[i] = '0; end
    for (int i = 0; i < 2; i++) begin s_a[i] = '0; s_b[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(m_busy), 64'd0);
    chk("reset ready", 64'(m_ready), 64'd0);
    chk("reset done", 64'(m_done), 64'd0);
    chk("reset err", 64'(m_err), 64'd0);
    chk("reset ovf", 64'(m_ovf), 64'd0);
    chk("reset out22", 64'(m_out[2][2]), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    load_s1();
    run(1'b0, 2, 0, 1'b0, "s1");
    chk("s1 c00 const", 64'(m_out[0][0]), 64'd19);
    chk("s1 c11 const", 64'(m_out[1][1]), 64'd50);

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        A[i][k] = 3 * i + k + 1;
        B[i][k] = 3 * i + k + 1;
      end
    run(1'b0, 3, -1, 1'b0, "s2");
    chk("s2 c22 const", 64'(m_out[2][2]), 64'd150);

    A[0][0] = -1; A[0][1] = 2; A[1][0] = 3; A[1][1] = -4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    run(1'b1, 2, 0, 1'b0, "s3");
    chk("s3 c11 const", 64'(s_out[1][1]), 64'(32'hFFFF_FFF2));

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = 255;
        B[k][i] = 255;
      end
    run(1'b0, 2, 0, 1'b0, "s4");
    chk("s4 c22 const", 64'(m_out[2][2]), 64'd64514);
    chk("s4 ovf const", 64'(m_ovf), 64'd1);
    fill(1'b0, 3);
    run(1'b0, 1, 0, 1'b0, "s4 clear");

    set_start(1'b0, 1'b1, 0);
    @(posedge clk); #1;
    set_start(1'b0, 1'b0, 0);
    chk("k0 done", 64'(m_done), 64'd1);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        chk($sformatf("k0 c%0d%0d", i, j), 64'(m_out[i][j]), 64'd0);
    @(posedge clk); #1;
    chk("k0 done end", 64'(m_done), 64'd0);
    chk("k0 idle", 64'(m_busy), 64'd0);

    fill(1'b0, 255);
    run(1'b0, 5, 20, 1'b0, "pre kmax");
    set_start(1'b0, 1'b1, KM + 1);
    @(posedge clk); #1;
    set_start(1'b0, 1'b0, 0);
    chk("kmax err", 64'(m_err), 64'd1);
    chk("kmax busy", 64'(m_busy), 64'd0);
    check_result(1'b0, "kmax hold");
    @(posedge clk); #1;
    chk("kmax err end", 64'(m_err), 64'd0);
    chk("kmax still idle", 64'(m_busy), 64'd0);

    fill(1'b0, 40);
    run(1'b0, 4, 30, 1'b1, "drain start");

    for (int r = 0; r < 6; r++) begin
      fill(1'b0, r[0] ? 255 : 20);
      run(1'b0, int'($urandom_range(1, KM)), 25, 1'b0, $sformatf("rnd%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      fill(1'b1, 0);
      run(1'b1, int'($urandom_range(1, KM)), 25, 1'b0, $sformatf("srnd%0d", r));
    end

    load_s1();
    set_start(1'b0, 1'b1, 3);
    @(posedge clk); #1;
    set_start(1'b0, 1'b0, 0);
    set_in(1'b0, 1'b1, 0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 1);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        chk($sformatf("abort c%0d%0d", i, j), 64'(m_out[i][j]), 64'd0);
    chk("abort ready", 64'(m_ready), 64'd0);
    chk("abort busy", 64'(m_busy), 64'd0);
    chk("abort ovf", 64'(m_ovf), 64'd0);
    set_in(1'b0, 1'b0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_done) seen++;
    end
    chk("abort no done", 64'(seen), 64'd0);
    run(1'b0, 2, 0, 1'b0, "after abort");
    chk("after abort c10 const", 64'(m_out[1][0]), 64'd43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
